// File: rtl/ysyx_22040931_load_ctrl_if.sv
// Data-memory read port between the load sequencer and memory.
// master: load sequencer side; slave: memory side.
interface ysyx_22040931_load_ctrl_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic        mem_rsp_ready;
  logic [63:0] mem_rsp_data;

  modport master (
    output mem_req_valid, mem_req_addr, mem_rsp_ready,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_rsp_ready,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data
  );
endinterface

// File: rtl/ysyx_22040931_load_ctrl.sv
// Multi-cycle load sequencer: issues one aligned dword read, extracts and
// extends the addressed byte/half/word/dword, returns it to writeback and
// stalls the pipeline while the load is in flight.
// Optional macro ALIGN_CHK_EN: misaligned half/word/dword loads are rejected
// with a one-cycle misalign pulse instead of being issued.
`ifndef ysyx_22040931_MNO
  `define ysyx_22040931_MNO    3'b000
  `define ysyx_22040931_R_ONE  3'b001
  `define ysyx_22040931_R_ONEU 3'b010
  `define ysyx_22040931_R_DOU  3'b011
  `define ysyx_22040931_R_DOUU 3'b100
  `define ysyx_22040931_R_FOR  3'b101
  `define ysyx_22040931_R_FORU 3'b110
  `define ysyx_22040931_R_EIG  3'b111
`endif

module ysyx_22040931_load_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ld_valid,
  output logic                             ld_ready,
  input  logic [2:0]                       memrop,
  input  logic [63:0]                      addr,
  input  logic [4:0]                       rd,
  ysyx_22040931_load_ctrl_if.master        mem,
  output logic                             wb_valid,
  output logic [4:0]                       wb_rd,
  output logic [63:0]                      wb_data,
  output logic                             stall,
  output logic                             timeout,
  output logic                             misalign
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_WB
`ifdef ALIGN_CHK_EN
    , S_ERR
`endif
  } state_t;

  state_t             state, state_nx;
  logic [2:0]         op_q;
  logic [2:0]         off_q;
  logic [60:0]        base_q;
  logic [4:0]         rd_q;
  logic [63:0]        data_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               accept;
  logic               expired;
  logic [63:0]        shifted;
  logic [63:0]        ext;

`ifdef ALIGN_CHK_EN
  function automatic logic is_misaligned(input logic [2:0] op, input logic [2:0] off);
    case (op)
      `ysyx_22040931_R_DOU, `ysyx_22040931_R_DOUU: is_misaligned = off[0];
      `ysyx_22040931_R_FOR, `ysyx_22040931_R_FORU: is_misaligned = |off[1:0];
      `ysyx_22040931_R_EIG:                        is_misaligned = |off;
      default:                                     is_misaligned = 1'b0;
    endcase
  endfunction
`endif

  assign accept  = (state == S_IDLE) && ld_valid && (memrop != `ysyx_22040931_MNO);
  assign expired = (state == S_WAIT) && !mem.mem_rsp_valid && (cnt_q == CNT_W'(TIMEOUT - 1));

  // Shifting the dword right zero-fills, so bytes past bit 63 read as zero.
  always_comb begin
    shifted = mem.mem_rsp_data >> {off_q, 3'b000};
    case (op_q)
      `ysyx_22040931_R_ONE:  ext = {{56{shifted[7]}},  shifted[7:0]};
      `ysyx_22040931_R_ONEU: ext = {56'd0,             shifted[7:0]};
      `ysyx_22040931_R_DOU:  ext = {{48{shifted[15]}}, shifted[15:0]};
      `ysyx_22040931_R_DOUU: ext = {48'd0,             shifted[15:0]};
      `ysyx_22040931_R_FOR:  ext = {{32{shifted[31]}}, shifted[31:0]};
      `ysyx_22040931_R_FORU: ext = {32'd0,             shifted[31:0]};
      default:               ext = shifted;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next state and per-state outputs.
  always_comb begin
    state_nx          = state;
    ld_ready          = 1'b0;
    mem.mem_req_valid = 1'b0;
    mem.mem_rsp_ready = 1'b0;
    wb_valid          = 1'b0;
    stall             = 1'b0;
    timeout           = 1'b0;
    misalign          = 1'b0;
    case (state)
      S_IDLE: begin
        ld_ready = 1'b1;
        stall    = accept;
        if (accept) begin
`ifdef ALIGN_CHK_EN
          state_nx = is_misaligned(memrop, addr[2:0]) ? S_ERR : S_REQ;
`else
          state_nx = S_REQ;
`endif
        end
      end
      S_REQ: begin
        mem.mem_req_valid = 1'b1;
        stall             = 1'b1;
        if (mem.mem_req_ready) state_nx = S_WAIT;
      end
      S_WAIT: begin
        mem.mem_rsp_ready = 1'b1;
        stall             = 1'b1;
        timeout           = expired;
        if (mem.mem_rsp_valid) state_nx = S_WB;
        else if (expired)      state_nx = S_IDLE;
      end
      S_WB: begin
        wb_valid = 1'b1;
        state_nx = S_IDLE;
      end
`ifdef ALIGN_CHK_EN
      S_ERR: begin
        misalign = 1'b1;
        stall    = 1'b1;
        state_nx = S_IDLE;
      end
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  // Latched load context, timeout counter and captured result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= '0;
      off_q  <= '0;
      base_q <= '0;
      rd_q   <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (accept) begin
        op_q   <= memrop;
        off_q  <= addr[2:0];
        base_q <= addr[63:3];
        rd_q   <= rd;
      end
      if (state == S_REQ && mem.mem_req_ready)
        cnt_q <= '0;
      else if (state == S_WAIT && !mem.mem_rsp_valid)
        cnt_q <= cnt_q + 1'b1;
      if (state == S_WAIT && mem.mem_rsp_valid)
        data_q <= ext;
    end
  end

  assign mem.mem_req_addr = {base_q, 3'b000};
  assign wb_rd            = rd_q;
  assign wb_data          = data_q;

endmodule

// File: tb/tb_ysyx_22040931_load_ctrl.sv
// Directed bench for the load sequencer, built with TIMEOUT=4.
module tb_ysyx_22040931_load_ctrl;

  localparam logic [2:0] OP_MNO = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LH  = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;
  localparam logic [2:0] OP_LW  = 3'b101;
  localparam logic [2:0] OP_LWU = 3'b110;
  localparam logic [2:0] OP_LD  = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid;
  logic        ld_ready;
  logic [2:0]  memrop;
  logic [63:0] addr;
  logic [4:0]  rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        stall;
  logic        timeout;
  logic        misalign;

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;

  ysyx_22040931_load_ctrl_if mem_bus ();

  ysyx_22040931_load_ctrl #(.TIMEOUT(4), .CNT_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .memrop   (memrop),
    .addr     (addr),
    .rd       (rd),
    .mem      (mem_bus.master),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .stall    (stall),
    .timeout  (timeout),
    .misalign (misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; return just after the edge so inputs can be changed safely.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full load transaction with req_wait cycles of mem_req_ready low and
  // rsp_wait WAIT cycles before the response arrives.
  task automatic run_load(input string tag, input logic [2:0] op, input logic [63:0] a,
                          input logic [4:0] r, input logic [63:0] exp_addr,
                          input int unsigned req_wait, input int unsigned rsp_wait,
                          input logic [63:0] data, input logic [63:0] exp);
    ld_valid = 1'b1; memrop = op; addr = a; rd = r;
    #1;
    check({tag, ".acc_stall"}, 64'(stall), 64'd1);
    check({tag, ".acc_req"}, 64'(mem_bus.mem_req_valid), 64'd0);
    tick();
    ld_valid = 1'b0; addr = '0; rd = '0;
    for (int unsigned i = 0; i < req_wait; i++) begin
      mem_bus.mem_req_ready = 1'b0;
      #1;
      check({tag, ".req_hold_valid"}, 64'(mem_bus.mem_req_valid), 64'd1);
      check({tag, ".req_hold_addr"}, mem_bus.mem_req_addr, exp_addr);
      check({tag, ".req_hold_to"}, 64'(timeout), 64'd0);
      tick();
    end
    mem_bus.mem_req_ready = 1'b1;
    #1;
    check({tag, ".req_valid"}, 64'(mem_bus.mem_req_valid), 64'd1);
    check({tag, ".req_addr"}, mem_bus.mem_req_addr, exp_addr);
    check({tag, ".req_stall"}, 64'(stall), 64'd1);
    check({tag, ".req_rspready"}, 64'(mem_bus.mem_rsp_ready), 64'd0);
    tick();
    mem_bus.mem_req_ready = 1'b0;
    for (int unsigned i = 0; i < rsp_wait; i++) begin
      #1;
      check({tag, ".wait_rspready"}, 64'(mem_bus.mem_rsp_ready), 64'd1);
      check({tag, ".wait_stall"}, 64'(stall), 64'd1);
      check({tag, ".wait_to"}, 64'(timeout), 64'd0);
      tick();
    end
    mem_bus.mem_rsp_valid = 1'b1; mem_bus.mem_rsp_data = data;
    #1;
    check({tag, ".rsp_ready"}, 64'(mem_bus.mem_rsp_ready), 64'd1);
    check({tag, ".rsp_to"}, 64'(timeout), 64'd0);
    tick();
    mem_bus.mem_rsp_valid = 1'b0; mem_bus.mem_rsp_data = '0;
    #1;
    check({tag, ".wb_valid"}, 64'(wb_valid), 64'd1);
    check({tag, ".wb_data"}, wb_data, exp);
    check({tag, ".wb_rd"}, 64'(wb_rd), 64'(r));
    check({tag, ".wb_stall"}, 64'(stall), 64'd0);
    tick();
    check({tag, ".post_wb_valid"}, 64'(wb_valid), 64'd0);
    check({tag, ".post_ld_ready"}, 64'(ld_ready), 64'd1);
    check({tag, ".post_wb_hold"}, wb_data, exp);
  endtask

  initial begin
    rst = 1'b1; ld_valid = 1'b0; memrop = OP_MNO; addr = '0; rd = '0;
    mem_bus.mem_req_ready = 1'b0; mem_bus.mem_rsp_valid = 1'b0; mem_bus.mem_rsp_data = '0;
    #1;
    check("rst.ld_ready", 64'(ld_ready), 64'd1);
    check("rst.req_valid", 64'(mem_bus.mem_req_valid), 64'd0);
    check("rst.rsp_ready", 64'(mem_bus.mem_rsp_ready), 64'd0);
    check("rst.wb_valid", 64'(wb_valid), 64'd0);
    check("rst.stall", 64'(stall), 64'd0);
    check("rst.wb_data", wb_data, 64'd0);
    check("rst.misalign", 64'(misalign), 64'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    run_load("lb", OP_LB, 64'h8000_0003, 5'd1, 64'h8000_0000, 0, 1,
             64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
    run_load("lwu", OP_LWU, 64'h10, 5'd2, 64'h10, 0, 0,
             64'hDEAD_BEEF_8765_4321, 64'h0000_0000_8765_4321);
    run_load("lw", OP_LW, 64'h10, 5'd3, 64'h10, 0, 2,
             64'hDEAD_BEEF_8765_4321, 64'hFFFF_FFFF_8765_4321);
    run_load("ld", OP_LD, 64'h20, 5'd4, 64'h20, 5, 0,
             64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
    run_load("lhu6", OP_LHU, 64'h16, 5'd5, 64'h10, 0, 3,
             64'hDEAD_BEEF_8765_4321, 64'h0000_0000_0000_DEAD);
    run_load("lh6", OP_LH, 64'h16, 5'd6, 64'h10, 1, 0,
             64'hDEAD_BEEF_8765_4321, 64'hFFFF_FFFF_FFFF_DEAD);
    run_load("lbu7", OP_LBU, 64'h4F, 5'd7, 64'h48, 0, 0,
             64'hA500_0000_0000_0000, 64'h0000_0000_0000_00A5);
    run_load("lb7", OP_LB, 64'h4F, 5'd8, 64'h48, 0, 0,
             64'hA500_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFA5);

    // Timeout: no response for 4 WAIT cycles.
    ld_valid = 1'b1; memrop = OP_LD; addr = 64'h30; rd = 5'd9;
    tick();
    ld_valid = 1'b0; mem_bus.mem_req_ready = 1'b1;
    tick();
    mem_bus.mem_req_ready = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      #1;
      check("to.early_pulse", 64'(timeout), 64'd0);
      check("to.wait_ready", 64'(mem_bus.mem_rsp_ready), 64'd1);
      tick();
    end
    #1;
    check("to.pulse", 64'(timeout), 64'd1);
    check("to.pulse_wb", 64'(wb_valid), 64'd0);
    tick();
    check("to.after_pulse", 64'(timeout), 64'd0);
    check("to.ld_ready", 64'(ld_ready), 64'd1);
    check("to.no_wb", 64'(wb_valid), 64'd0);
    mem_bus.mem_rsp_valid = 1'b1; mem_bus.mem_rsp_data = 64'h1111;
    #1;
    check("to.late_rsp_ready", 64'(mem_bus.mem_rsp_ready), 64'd0);
    tick();
    check("to.late_no_wb", 64'(wb_valid), 64'd0);
    mem_bus.mem_rsp_valid = 1'b0;
    tick();

    // Asynchronous reset in WAIT, then a late response.
    ld_valid = 1'b1; memrop = OP_LW; addr = 64'h40; rd = 5'd10;
    tick();
    ld_valid = 1'b0; mem_bus.mem_req_ready = 1'b1;
    tick();
    mem_bus.mem_req_ready = 1'b0;
    #1;
    check("rw.in_wait", 64'(mem_bus.mem_rsp_ready), 64'd1);
    rst = 1'b1;
    #1;
    check("rw.rsp_ready", 64'(mem_bus.mem_rsp_ready), 64'd0);
    check("rw.ld_ready", 64'(ld_ready), 64'd1);
    check("rw.stall", 64'(stall), 64'd0);
    rst = 1'b0;
    mem_bus.mem_rsp_valid = 1'b1; mem_bus.mem_rsp_data = 64'h2222;
    for (int unsigned i = 0; i < 2; i++) begin
      tick();
      check("rw.late_rsp_ready", 64'(mem_bus.mem_rsp_ready), 64'd0);
      check("rw.late_no_wb", 64'(wb_valid), 64'd0);
      check("rw.no_timeout", 64'(timeout), 64'd0);
    end
    mem_bus.mem_rsp_valid = 1'b0;
    check("rw.wb_data_cleared", wb_data, 64'd0);

    // MNO op is ignored.
    ld_valid = 1'b1; memrop = OP_MNO; addr = 64'h50;
    #1;
    check("mno.stall", 64'(stall), 64'd0);
    tick();
    check("mno.req_valid", 64'(mem_bus.mem_req_valid), 64'd0);
    check("mno.ld_ready", 64'(ld_ready), 64'd1);
    ld_valid = 1'b0;
    tick();

    // Misaligned halfword.
`ifdef ALIGN_CHK_EN
    ld_valid = 1'b1; memrop = OP_LH; addr = 64'h101; rd = 5'd11;
    #1;
    check("mis.acc_stall", 64'(stall), 64'd1);
    tick();
    ld_valid = 1'b0;
    check("mis.pulse", 64'(misalign), 64'd1);
    check("mis.no_req", 64'(mem_bus.mem_req_valid), 64'd0);
    check("mis.stall", 64'(stall), 64'd1);
    tick();
    check("mis.after", 64'(misalign), 64'd0);
    check("mis.ld_ready", 64'(ld_ready), 64'd1);
    check("mis.no_wb", 64'(wb_valid), 64'd0);
`else
    run_load("lh_mis", OP_LH, 64'h101, 5'd11, 64'h100, 0, 0,
             64'h0000_0000_00F0_0D00, 64'hFFFF_FFFF_FFFF_F00D);
    check("mis.tied0", 64'(misalign), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
